// File: rtl/cc_pkg.sv
// cc_pkg: shared types and constants for the draw controller.
// FSM state enum, default pool depth, pool data width.
package cc_pkg;

  localparam int POOL_SIZE_DEF = 400;
  localparam int DATA_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARB,
    ST_READ,
    ST_WAIT,
    ST_DELIVER
  } cc_state_e;

endpackage

// File: rtl/cc_rr_arb.sv
// cc_rr_arb: combinational round-robin pick.
// In: req, ptr (last granted). Out: pick_oh, pick_idx, pick_any.
module cc_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick_oh,
  output logic [IW-1:0]   pick_idx,
  output logic            pick_any
);

  logic [IW-1:0] c;

  // Scan from farthest to nearest offset so the
  // index just above ptr is the last (winning) write.
  always_comb begin
    c        = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      c = IW'((int'(ptr) + i) % NREQ);
      if (req[c]) begin
        pick_idx = c;
        pick_any = 1'b1;
      end
    end
    pick_oh = '0;
    if (pick_any) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/cc_draw_ctrl.sv
// cc_draw_ctrl: shares a number-pool generator among NREQ requesters.
// Ports: req/gnt/dout to clients; pool_* to generator; remaining/busy/err status.
module cc_draw_ctrl
  import cc_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int POOL_SIZE = POOL_SIZE_DEF,
  parameter int RD_W      = 2,
  parameter int RD_LAT    = 2,
  parameter int FILL_TMO  = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [DATA_W-1:0] dout,
  output logic              pool_start,
  input  logic              pool_ready,
  output logic              pool_read,
  input  logic [DATA_W-1:0] pool_num,
  output logic [8:0]        remaining,
  output logic              busy,
  output logic              err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(FILL_TMO + RD_W + RD_LAT + 1);

  cc_state_e state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [8:0]        rem_q;
  logic              err_q;
  logic [IW-1:0]     ptr_q, idx_q;
  logic [NREQ-1:0]   oh_q;
  logic [DATA_W-1:0] data_q;

  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  logic fill_ok, fill_tmo, arb_take, cap, deliver;

  cc_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .pick_oh  (arb_oh),
    .pick_idx (arb_idx),
    .pick_any (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    pool_start = 1'b0;
    pool_read  = 1'b0;
    gnt        = '0;
    dout       = '0;
    fill_ok    = 1'b0;
    fill_tmo   = 1'b0;
    arb_take   = 1'b0;
    cap        = 1'b0;
    deliver    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req)
          state_d = (rem_q == '0) ? ST_FILL : ST_ARB;
      end
      ST_FILL: begin
        cnt_d = cnt_q + CW'(1);
        // entry cycle only pulses start; a stale
        // pool_ready from the last fill is ignored
        if (cnt_q == '0) begin
          pool_start = 1'b1;
        end else if (pool_ready) begin
          fill_ok = 1'b1;
          state_d = ST_ARB;
          cnt_d   = '0;
        end else if (cnt_q == CW'(FILL_TMO)) begin
          fill_tmo = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end
      end
      ST_ARB: begin
        arb_take = arb_any;
        state_d  = arb_any ? ST_READ : ST_IDLE;
      end
      ST_READ: begin
        pool_read = 1'b1;
        if (cnt_q == CW'(RD_W - 1))
          state_d = ST_WAIT;
        else
          cnt_d = cnt_q + CW'(1);
      end
      ST_WAIT: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          cap     = 1'b1;
          state_d = ST_DELIVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DELIVER: begin
        deliver = 1'b1;
        gnt     = oh_q;
        dout    = data_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      ptr_q   <= IW'(NREQ - 1);
      idx_q   <= '0;
      oh_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fill_ok)
        rem_q <= 9'(POOL_SIZE);
      else if (deliver && rem_q != '0)
        rem_q <= rem_q - 9'd1;
      if (fill_tmo) err_q <= 1'b1;
      if (arb_take) begin
        idx_q <= arb_idx;
        oh_q  <= arb_oh;
      end
      if (cap) data_q <= pool_num;
      if (deliver) ptr_q <= idx_q;
    end
  end

  assign remaining = rem_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_cc_draw_ctrl.sv
// tb_cc_draw_ctrl: directed bench for cc_draw_ctrl.
// Generator model raises pool_ready 10 cycles after pool_start.
module tb_cc_draw_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [7:0] dout;
  logic       pool_start;
  logic       pool_ready;
  logic       pool_read;
  logic [7:0] pool_num = '0;
  logic [8:0] remaining;
  logic       busy;
  logic       err;

  int passed    = 0;
  int total     = 0;
  int cyc       = 0;
  int start_cnt = 0;
  int gnt_cnt   = 0;
  bit gen_en    = 1'b1;

  cc_draw_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .dout       (dout),
    .pool_start (pool_start),
    .pool_ready (pool_ready),
    .pool_read  (pool_read),
    .pool_num   (pool_num),
    .remaining  (remaining),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int rc;
    rc = 0;
    pool_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pool_start) start_cnt++;
      if (gnt != '0) gnt_cnt++;
      if (rst) begin
        pool_ready = 1'b0;
        rc = 0;
      end else if (pool_start) begin
        pool_ready = 1'b0;
        rc = gen_en ? 10 : 0;
      end else if (rc > 0) begin
        rc--;
        if (rc == 0) pool_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (gnt != '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit ok;
    int t0, s0, g0;
    int tg[5];
    logic [3:0] seq[5];
    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b0100;
    seq[3] = 4'b1000;
    seq[4] = 4'b0001;

    // reset values
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_err", err, 0);
    chk("rst_start", pool_start, 0);
    chk("rst_read", pool_read, 0);
    rst = 1'b0;

    // first draw: fill then grant
    pool_num = 8'hA5;
    req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (remaining == 9'd400) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t1_fill_to", ok, 1);
    chk("t1_starts", start_cnt, 1);
    t0 = cyc;
    wait_gnt(20, ok);
    chk("t1_gnt_to", ok, 1);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_dout", dout, 8'hA5);
    chk("t1_lat", cyc - t0, 5);
    req = '0;
    step();
    chk("t1_rem", remaining, 399);
    chk("t1_gnt_off", gnt, 0);

    // round robin from fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'hF;
    pool_num = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(60, ok);
      chk("rr_to", ok, 1);
      chk("rr_gnt", gnt, seq[k]);
      chk("rr_dout", dout, 8'h3C);
      tg[k] = cyc;
    end
    req = '0;
    for (int k = 1; k < 5; k++)
      chk("rr_space", tg[k] - tg[k-1], 7);
    step();
    chk("rr_rem", remaining, 395);

    // drain to one remaining
    req = 4'b0001;
    pool_num = 8'h11;
    for (int i = 0; i < 394; i++) begin
      wait_gnt(20, ok);
      if (!ok) break;
    end
    chk("drain_to", ok, 1);
    req = '0;
    step();
    chk("drain_rem", remaining, 1);
    req = 4'b0100;
    pool_num = 8'h77;
    wait_gnt(20, ok);
    chk("last_to", ok, 1);
    chk("last_gnt", gnt, 4'b0100);
    chk("last_dout", dout, 8'h77);
    req = '0;
    step();
    chk("last_rem", remaining, 0);
    s0 = start_cnt;
    req = 4'b0001;
    wait_gnt(60, ok);
    chk("refill_to", ok, 1);
    chk("refill_start", start_cnt, s0 + 1);
    chk("refill_rem", remaining, 400);
    req = '0;
    step();
    chk("refill_rem2", remaining, 399);

    // request dropped after ARB still granted
    req = 4'b0010;
    step();
    chk("drop_arb_busy", busy, 1);
    chk("drop_arb_read", pool_read, 0);
    t0 = cyc;
    step();
    req = '0;
    chk("drop_read", pool_read, 1);
    wait_gnt(20, ok);
    chk("drop_to", ok, 1);
    chk("drop_gnt", gnt, 4'b0010);
    chk("drop_lat", cyc - t0, 5);
    step();
    chk("drop_rem", remaining, 398);

    // request gone by ARB: back to idle
    req = 4'b1000;
    step();
    req = '0;
    g0 = gnt_cnt;
    step();
    chk("noreq_busy", busy, 0);
    chk("noreq_read", pool_read, 0);
    chk("noreq_rem", remaining, 398);
    repeat (10) step();
    chk("noreq_gnts", gnt_cnt, g0);

    // reset during WAIT
    req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pool_read) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wrst_read_to", ok, 1);
    while (pool_read) step();
    chk("wrst_in_wait", busy, 1);
    rst = 1'b1;
    req = '0;
    g0 = gnt_cnt;
    step();
    chk("wrst_gnt", gnt, 0);
    chk("wrst_busy", busy, 0);
    chk("wrst_dout", dout, 0);
    chk("wrst_rem", remaining, 0);
    chk("wrst_read", pool_read, 0);
    chk("wrst_start", pool_start, 0);
    rst = 1'b0;
    repeat (10) step();
    chk("wrst_gnts", gnt_cnt, g0);

    // fill timeout
    gen_en = 1'b0;
    req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pool_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_start_to", ok, 1);
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (err) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_err_to", ok, 1);
    chk("tmo_cycles", cyc - t0, 4096);
    chk("tmo_busy", busy, 0);
    chk("tmo_gnts", gnt_cnt, g0);
    req = '0;

    // err sticky, fill retried
    gen_en = 1'b1;
    req = 4'b0001;
    wait_gnt(60, ok);
    chk("sticky_to", ok, 1);
    chk("sticky_err", err, 1);
    req = '0;
    rst = 1'b1;
    step();
    chk("err_clr", err, 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
